pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  instruction address, equals pc_out.
REQ-006 imem_ready  in  1  memory has imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 inst_out  out  32  latched instruction presented to the controller.
REQ-009 opcode  out  6  inst_out[31:26].
REQ-010 func  out  6  inst_out[5:0].
REQ-011 inst_valid  out  1  inst_out is executing this cycle.
REQ-012 pc_out  out  32  address of current instruction.
REQ-013 pc_plus4  out  32  pc_out+4, modulo 2^32, used as the jal/jalr link value.
REQ-014 jump  in  2  from controller: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 reserved.
REQ-015 beq, bne  in  1 each  from controller.
REQ-016 alu_zero  in  1  ALU zero flag for the current instruction.
REQ-017 rs_data  in  32  register rs value (jr/jalr target).
REQ-018 stall  in  1  hold current instruction in execute.
REQ-019 addr_err  out  1  sticky misaligned-jr-target flag.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH and EXEC.
- IDLE -> FETCH unconditionally.
- FETCH -> EXEC when imem_ready=1.
- EXEC -> FETCH when stall=0; stays in EXEC when stall=1.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc_out; imem_req SHALL be 0 in all other states.
REQ-022 On the FETCH cycle with imem_ready=1, inst_out SHALL load imem_rdata, visible from the next cycle.
REQ-023 imem_ready SHALL be ignored outside FETCH; inst_out holds its value.
REQ-024 inst_valid SHALL be 1 exactly in EXEC, including every stalled EXEC cycle.
REQ-025 The next PC SHALL be computed combinationally in EXEC from inst_out, jump, beq, bne, alu_zero and rs_data, and loaded into pc_out on the EXEC cycle with stall=0.
REQ-026 Next-PC selection (highest priority first):
- jump=01: {pc_plus4[31:28], inst_out[25:0], 2'b00}.
- jump=10: {rs_data[31:2], 2'b00}.
- jump=00 and ((beq and alu_zero) or (bne and not alu_zero)): pc_plus4 + (sign-extended inst_out[15:0] << 2), modulo 2^32.
- otherwise, including jump=11: pc_plus4.
REQ-027 If beq and bne are both 1, the block SHALL branch when either condition holds.
REQ-028 A jump=10 EXEC commit with rs_data[1:0]!=0 SHALL set addr_err on the commit edge; addr_err SHALL stay set until reset.
REQ-029 pc_out=32'hFFFF_FFFC sequential SHALL wrap to 32'h0000_0000.
REQ-030 pc_out SHALL change only on an EXEC commit or on reset.
REQ-031 Minimum throughput SHALL be one instruction per 2 cycles (imem_ready=1 in the first FETCH cycle).

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, pc_out=RESET_PC, inst_out=0, inst_valid=0, imem_req=0 and addr_err=0.
REQ-033 Reset in FETCH or EXEC SHALL abandon the operation; imem_req=0 and inst_valid=0 from the next cycle, with no PC commit.
REQ-034 Reset SHALL take priority over stall and imem_ready.

Verification
REQ-035 Reset then imem_ready held 1, sequential instructions -> pc_out 0,4,8; inst_valid every other cycle; imem_req 0 in the first cycle after reset.
REQ-036 pc=0x100, inst_out=beq imm 16'hFFFE, beq=1, alu_zero=1 -> next pc_out 0x0FC; with alu_zero=0 -> 0x104.
REQ-037 pc=0x4000_0010, j with inst_out[25:0]=0x000_0040 -> pc_out 0x4000_0100; jr with rs_data=0x0000_2003 -> pc_out 0x2000, addr_err=1 held.
REQ-038 stall=1 for 3 EXEC cycles -> inst_valid high 3+1 cycles; pc_out and inst_out unchanged until stall drops.
REQ-039 imem_ready low for 4 FETCH cycles, then high -> imem_req high 5 cycles, imem_addr stable; imem_ready pulse during EXEC ignored.
REQ-040 rst_n low mid-FETCH at pc=0x20 -> next cycle pc_out=RESET_PC, imem_req=0, addr_err=0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// ============================================================================
// pc_fetch_if : instruction-memory read channel between fetch unit and memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : IDLE/FETCH/EXEC fetch sequencer with next-PC selection
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pc_fetch_if.master       imem,
  output logic [31:0]      inst_out,
  output logic [5:0]       opcode,
  output logic [5:0]       func,
  output logic             inst_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  input  wire logic [1:0]  jump,
  input  wire logic        beq,
  input  wire logic        bne,
  input  wire logic        alu_zero,
  input  wire logic [31:0] rs_data,
  input  wire logic        stall,
  output logic             addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic        w_br_taken;
  logic [31:0] w_next_pc;

  always_comb begin
    w_pc_plus4 = pc_q + 32'd4;
    w_br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    // Both beq and bne asserted means branch on either outcome.
    w_br_taken = (beq && alu_zero) || (bne && !alu_zero);
    case (jump)
      2'b01:   w_next_pc = {w_pc_plus4[31:28], inst_q[25:0], 2'b00};
      2'b10:   w_next_pc = {rs_data[31:2], 2'b00};
      2'b00:   w_next_pc = w_br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          inst_d  = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_d    = w_next_pc;
          state_d = FETCH;
          if ((jump == 2'b10) && (rs_data[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst_out       = inst_q;
  assign opcode         = inst_q[31:26];
  assign func           = inst_q[5:0];
  assign inst_valid     = valid_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = w_pc_plus4;
  assign addr_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// tb_pc_fetch_unit : scoreboard bench for pc_fetch_unit
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_out, pc_out, pc_plus4, rs_data;
  logic [5:0]  opcode, func;
  logic        inst_valid, beq, bne, alu_zero, stall, addr_err;
  logic [1:0]  jump;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        exp_err;

  localparam logic [31:0] W_ADD = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] W_JR  = {6'h00, 5'd3, 15'd0, 6'h08};

  always #5 clk = ~clk;

  pc_fetch_if imem ();

  pc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .inst_out   (inst_out),
    .opcode     (opcode),
    .func       (func),
    .inst_valid (inst_valid),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .alu_zero   (alu_zero),
    .rs_data    (rs_data),
    .stall      (stall),
    .addr_err   (addr_err)
  );

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic [1:0] j, input logic b_eq,
                                             input logic b_ne, input logic z,
                                             input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j == 2'd1) return (p4 & 32'hF000_0000) | ({6'd0, inst[25:0]} << 2);
    if (j == 2'd2) return rs & 32'hFFFF_FFFC;
    if ((j == 2'd0) && ((b_eq && z) || (b_ne && !z))) begin
      off = int'($signed(inst[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    jump = 2'b00; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
    rs_data = 32'h0; stall = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] word, input int waits);
    int          n;
    int          req_cycles;
    logic [31:0] a;
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", imem.imem_req);
    end
    a = imem.imem_addr;
    n_tests++;
    if (a !== pc_out || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_addr: imem_addr=%h pc_out=%h inst_valid=%b required addr=pc, valid 0",
               a, pc_out, inst_valid);
    end
    req_cycles = 1;
    for (int i = 0; i < waits; i++) begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = 32'hDEAD_0000 | 32'(i);
      @(negedge clk);
      if (imem.imem_req === 1'b1 && imem.imem_addr === a) req_cycles++;
    end
    n_tests++;
    if (req_cycles != waits + 1) begin
      n_fail++;
      $display("FAIL fetch_req_hold: stable req cycles=%0d required %0d", req_cycles, waits + 1);
    end
    imem.imem_ready = 1'b1;
    imem.imem_rdata = word;
    @(negedge clk);
    imem.imem_ready = 1'b0;
    n_tests++;
    if (imem.imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_out !== word ||
        opcode !== word[31:26] || func !== word[5:0]) begin
      n_fail++;
      $display("FAIL exec_entry: req=%b valid=%b inst=%h op=%h fn=%h required 0 1 %h %h %h",
               imem.imem_req, inst_valid, inst_out, opcode, func, word, word[31:26], word[5:0]);
    end
  endtask

  task automatic exec_one(input logic [1:0] j, input logic b_eq, input logic b_ne,
                          input logic z, input logic [31:0] rs, input int stalls,
                          input logic pulse);
    logic [31:0] pc0, inst0, got;
    int          v;
    pc0 = pc_out;
    inst0 = inst_out;
    jump = j; beq = b_eq; bne = b_ne; alu_zero = z; rs_data = rs;
    exp_q.push_back(model_next(pc0, inst0, j, b_eq, b_ne, z, rs));
    if (j == 2'd2 && rs[1:0] != 2'b00) exp_err = 1'b1;
    n_tests++;
    if (pc_plus4 !== pc0 + 32'd4) begin
      n_fail++;
      $display("FAIL pc_plus4: got %h required %h", pc_plus4, pc0 + 32'd4);
    end
    v = (inst_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      if (pulse) begin
        imem.imem_ready = 1'b1;
        imem.imem_rdata = ~inst0;
      end
      @(negedge clk);
      imem.imem_ready = 1'b0;
      if (inst_valid === 1'b1) v++;
      n_tests++;
      if (pc_out !== pc0 || inst_out !== inst0 || imem.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: pc=%h inst=%h req=%b required %h %h 0",
                 pc_out, inst_out, imem.imem_req, pc0, inst0);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (v != stalls + 1 || inst_valid !== 1'b0 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL exec_valid: valid cycles=%0d valid=%b req=%b required %0d 0 1",
               v, inst_valid, imem.imem_req, stalls + 1);
    end
    got = exp_q.pop_front();
    n_tests++;
    if (pc_out !== got || imem.imem_addr !== got) begin
      n_fail++;
      $display("FAIL next_pc: pc_out=%h imem_addr=%h required %h", pc_out, imem.imem_addr, got);
    end
    n_tests++;
    if (addr_err !== exp_err) begin
      n_fail++;
      $display("FAIL addr_err: got %b required %b", addr_err, exp_err);
    end
    jump = 2'b00; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0; rs_data = 32'h0;
  endtask

  task automatic run_inst(input logic [31:0] word, input logic [1:0] j, input logic b_eq,
                          input logic b_ne, input logic z, input logic [31:0] rs);
    fetch_one(word, 0);
    exec_one(j, b_eq, b_ne, z, rs, 0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (pc_out !== 32'h0 || inst_out !== 32'h0 || inst_valid !== 1'b0 ||
        imem.imem_req !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h inst=%h valid=%b req=%b err=%b required 0 0 0 0 0",
               pc_out, inst_out, inst_valid, imem.imem_req, addr_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem.imem_req !== 1'b1 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL first_fetch: req=%b pc=%h required 1 0", imem.imem_req, pc_out);
    end
  endtask

  task automatic test_sequential();
    run_inst(W_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    run_inst(W_ADD, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
    run_inst(W_ADD, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (pc_out !== 32'h0000_000C) begin
      n_fail++;
      $display("FAIL seq_pc: got %h required 0000000c", pc_out);
    end
  endtask

  task automatic test_branch();
    run_inst({6'h02, 26'h000_0040}, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    run_inst({6'h04, 5'd1, 5'd2, 16'hFFFE}, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0);
    n_tests++;
    if (pc_out !== 32'h0000_00FC) begin
      n_fail++;
      $display("FAIL beq_taken: got %h required 000000fc", pc_out);
    end
    run_inst(W_JR, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
    run_inst({6'h04, 5'd1, 5'd2, 16'hFFFE}, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (pc_out !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL beq_not_taken: got %h required 00000104", pc_out);
    end
    run_inst({6'h05, 5'd1, 5'd2, 16'h0010}, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    run_inst({6'h05, 5'd1, 5'd2, 16'h0008}, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0);
    run_inst({6'h04, 5'd1, 5'd2, 16'h0020}, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
    run_inst({6'h04, 5'd1, 5'd2, 16'h0020}, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_jump();
    run_inst(W_JR, 2'b10, 1'b0, 1'b0, 1'b0, 32'h4000_0010);
    run_inst({6'h02, 26'h000_0040}, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (pc_out !== 32'h4000_0100) begin
      n_fail++;
      $display("FAIL j_target: got %h required 40000100", pc_out);
    end
    run_inst(W_JR, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_2003);
    n_tests++;
    if (pc_out !== 32'h0000_2000 || addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_misaligned: pc=%h err=%b required 00002000 1", pc_out, addr_err);
    end
    run_inst(W_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    run_inst(W_JR, 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    run_inst(W_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++;
    if (pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h required 00000000", pc_out);
    end
  endtask

  task automatic test_stall();
    fetch_one(32'h1234_5678, 0);
    exec_one(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 3, 1'b1);
  endtask

  task automatic test_fetch_wait();
    fetch_one(32'h0C00_0100, 4);
    exec_one(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    run_inst(W_JR, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0021);
    n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (pc_out !== 32'h0000_0020 || addr_err !== 1'b1 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: pc=%h err=%b req=%b required 00000020 1 1",
               pc_out, addr_err, imem.imem_req);
    end
    rst_n = 1'b0;
    imem.imem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pc_out !== 32'h0 || imem.imem_req !== 1'b0 || addr_err !== 1'b0 ||
        inst_valid !== 1'b0 || inst_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fetch: pc=%h req=%b err=%b valid=%b inst=%h required 0 0 0 0 0",
               pc_out, imem.imem_req, addr_err, inst_valid, inst_out);
    end
    imem.imem_ready = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    run_inst(W_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_one(W_JR, 0);
    jump = 2'b10;
    rs_data = 32'h0000_0303;
    stall = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pc_out !== 32'h0 || inst_valid !== 1'b0 || imem.imem_req !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_exec: pc=%h valid=%b req=%b err=%b required 0 0 0 0",
               pc_out, inst_valid, imem.imem_req, addr_err);
    end
    stall = 1'b0;
    jump = 2'b00;
    rs_data = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem.imem_req !== 1'b1 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL restart: req=%b pc=%h required 1 0", imem.imem_req, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_stall();
    test_fetch_wait();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
